// File: rtl/m_mem_arb_if.sv
// Bus bundle between the fetch port, the data port, the memory and the arbiter.
// The slave modport is the arbiter's view; master is the surrounding pipeline and memory.
interface m_mem_arb_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              w_i_req;
  logic [ADDR_W-1:0] w_i_addr;
  logic              w_i_gnt;
  logic              w_i_rvalid;
  logic [DATA_W-1:0] w_i_rdata;

  logic              w_d_req;
  logic              w_d_we;
  logic [ADDR_W-1:0] w_d_addr;
  logic [DATA_W-1:0] w_d_wdata;
  logic              w_d_gnt;
  logic              w_d_rvalid;
  logic [DATA_W-1:0] w_d_rdata;

  logic              w_m_req;
  logic              w_m_we;
  logic [ADDR_W-1:0] w_m_addr;
  logic [DATA_W-1:0] w_m_wdata;
  logic              w_m_ready;
  logic              w_m_rvalid;
  logic [DATA_W-1:0] w_m_rdata;

  logic              w_busy;
  logic              w_err;

  modport slave (
    input  w_i_req, w_i_addr,
    output w_i_gnt, w_i_rvalid, w_i_rdata,
    input  w_d_req, w_d_we, w_d_addr, w_d_wdata,
    output w_d_gnt, w_d_rvalid, w_d_rdata,
    output w_m_req, w_m_we, w_m_addr, w_m_wdata,
    input  w_m_ready, w_m_rvalid, w_m_rdata,
    output w_busy, w_err
  );

  modport master (
    output w_i_req, w_i_addr,
    input  w_i_gnt, w_i_rvalid, w_i_rdata,
    output w_d_req, w_d_we, w_d_addr, w_d_wdata,
    input  w_d_gnt, w_d_rvalid, w_d_rdata,
    input  w_m_req, w_m_we, w_m_addr, w_m_wdata,
    output w_m_ready, w_m_rvalid, w_m_rdata,
    input  w_busy, w_err
  );
endinterface

// File: rtl/m_mem_arb.sv
// Single-port memory arbiter: fetch (I) and data (D) ports share one memory, one
// transaction in flight, D has priority with a streak limit that forces I through.
module m_mem_arb #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int DSTREAK = 4
) (
  input  logic          w_clk,
  input  logic          w_rst_n,
  m_mem_arb_if.slave    bus
);

  localparam int SW = $clog2(DSTREAK + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(DSTREAK);

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT} state_e;
  typedef enum logic {OWN_I, OWN_D} owner_e;

  state_e            r_state;
  state_e            w_state_nxt;
  owner_e            r_owner;
  logic [SW-1:0]     r_streak;
  logic              r_m_we;
  logic [ADDR_W-1:0] r_m_addr;
  logic [DATA_W-1:0] r_m_wdata;
  logic              r_i_rvalid;
  logic              r_d_rvalid;
  logic [DATA_W-1:0] r_i_rdata;
  logic [DATA_W-1:0] r_d_rdata;
  logic              r_err;
  logic              w_i_gnt;
  logic              w_d_gnt;
  logic              w_resp;

  // Grants are qualified with w_rst_n so none leak out while reset holds IDLE.
  // NOTE: every always_comb output gets a default first, so no path infers a latch.
  always_comb begin
    w_i_gnt     = 1'b0;
    w_d_gnt     = 1'b0;
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_rst_n) begin
          if (bus.w_d_req && !(bus.w_i_req && (r_streak == STREAK_MAX))) begin
            w_d_gnt = 1'b1;
          end else if (bus.w_i_req) begin
            w_i_gnt = 1'b1;
          end
        end
        if (w_i_gnt || w_d_gnt) begin
          w_state_nxt = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (bus.w_m_ready) begin
          w_state_nxt = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (bus.w_m_rvalid) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign w_resp = (r_state == ST_WAIT) && bus.w_m_rvalid;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Request registers are loaded only on a grant, so they hold through ISSUE.
  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_owner   <= OWN_I;
      r_m_we    <= 1'b0;
      r_m_addr  <= '0;
      r_m_wdata <= '0;
    end else if (w_d_gnt) begin
      r_owner   <= OWN_D;
      r_m_we    <= bus.w_d_we;
      r_m_addr  <= bus.w_d_addr;
      r_m_wdata <= bus.w_d_wdata;
    end else if (w_i_gnt) begin
      r_owner   <= OWN_I;
      r_m_we    <= 1'b0;
      r_m_addr  <= bus.w_i_addr;
      r_m_wdata <= '0;
    end
  end

  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_streak <= '0;
    end else if (w_d_gnt && bus.w_i_req) begin
      if (r_streak != STREAK_MAX) begin
        r_streak <= r_streak + SW'(1);
      end
    end else if (w_d_gnt || w_i_gnt) begin
      r_streak <= '0;
    end
  end

  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_i_rvalid <= 1'b0;
      r_d_rvalid <= 1'b0;
      r_i_rdata  <= '0;
      r_d_rdata  <= '0;
    end else begin
      r_i_rvalid <= w_resp && (r_owner == OWN_I);
      r_d_rvalid <= w_resp && (r_owner == OWN_D);
      if (w_resp && (r_owner == OWN_I)) begin
        r_i_rdata <= bus.w_m_rdata;
      end
      if (w_resp && (r_owner == OWN_D)) begin
        r_d_rdata <= bus.w_m_rdata;
      end
    end
  end

  // A response with no transaction waiting for it is a protocol fault; remember it.
  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_err <= 1'b0;
    end else if (bus.w_m_rvalid && (r_state != ST_WAIT)) begin
      r_err <= 1'b1;
    end
  end

  assign bus.w_i_gnt    = w_i_gnt;
  assign bus.w_d_gnt    = w_d_gnt;
  assign bus.w_i_rvalid = r_i_rvalid;
  assign bus.w_d_rvalid = r_d_rvalid;
  assign bus.w_i_rdata  = r_i_rdata;
  assign bus.w_d_rdata  = r_d_rdata;
  assign bus.w_m_req    = (r_state == ST_ISSUE);
  assign bus.w_m_we     = r_m_we;
  assign bus.w_m_addr   = r_m_addr;
  assign bus.w_m_wdata  = r_m_wdata;
  assign bus.w_busy     = (r_state != ST_IDLE);
  assign bus.w_err      = r_err;

endmodule

// File: tb/tb_m_mem_arb.sv
// Directed bench for m_mem_arb: behavioural memory, response scoreboard and
// cycle-accurate checks of grant order, timeline, backpressure, errors and reset.
module tb_m_mem_arb;

  localparam int AW      = 32;
  localparam int DW      = 32;
  localparam int DSTREAK = 4;

  logic w_clk   = 1'b0;
  logic w_rst_n = 1'b0;

  always #5 w_clk = ~w_clk;

  m_mem_arb_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  m_mem_arb #(.ADDR_W(AW), .DATA_W(DW), .DSTREAK(DSTREAK)) dut (
    .w_clk   (w_clk),
    .w_rst_n (w_rst_n),
    .bus     (bus)
  );

  typedef struct {
    logic        is_d;
    logic        chk;
    logic [31:0] data;
  } exp_t;

  int          n_vec = 0;
  int          n_err = 0;
  int          n_rv  = 0;
  exp_t        sb[$];
  logic        gseq[$];
  logic [31:0] mem [logic [31:0]];

  int          ready_delay = 0;
  int          rv_delay    = 0;
  int          iss_cnt     = 0;
  int          wait_cnt    = 0;
  logic        inject_rvalid = 1'b0;
  logic        pend_we    = 1'b0;
  logic [31:0] pend_addr  = '0;
  logic [31:0] pend_wdata = '0;
  logic [31:0] exp_i_data = '0;
  logic [31:0] exp_d_data = '0;

  function automatic logic [31:0] init_val(input logic [31:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : init_val(a);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    check(tag, 32'(obs), 32'(exp));
  endtask

  // One clock: record grants at the negedge, then at posedge+1 play the memory
  // and compare any response against the scoreboard.
  task automatic tick();
    exp_t e;
    @(negedge w_clk);
    chk1("gnt_exclusive", bus.w_i_gnt & bus.w_d_gnt, 1'b0);
    if (bus.w_d_gnt) begin
      e.is_d = 1'b1; e.chk = !bus.w_d_we; e.data = exp_d_data;
      sb.push_back(e);
      gseq.push_back(1'b1);
    end else if (bus.w_i_gnt) begin
      e.is_d = 1'b0; e.chk = 1'b1; e.data = exp_i_data;
      sb.push_back(e);
      gseq.push_back(1'b0);
    end
    @(posedge w_clk);
    #1;
    if (bus.w_m_req) begin
      bus.w_m_ready = (iss_cnt >= ready_delay);
      if (bus.w_m_ready) begin
        pend_we    = bus.w_m_we;
        pend_addr  = bus.w_m_addr;
        pend_wdata = bus.w_m_wdata;
      end
      iss_cnt++;
    end else begin
      bus.w_m_ready = 1'b0;
      iss_cnt = 0;
    end
    if (bus.w_busy && !bus.w_m_req) begin
      if (wait_cnt == rv_delay) begin
        bus.w_m_rvalid = 1'b1;
        if (pend_we) begin
          mem[pend_addr] = pend_wdata;
          bus.w_m_rdata  = $urandom;
        end else begin
          bus.w_m_rdata = mem_rd(pend_addr);
        end
      end else begin
        bus.w_m_rvalid = 1'b0;
      end
      wait_cnt++;
    end else begin
      wait_cnt = 0;
      bus.w_m_rvalid = inject_rvalid;
      bus.w_m_rdata  = 32'hBAD0_BAD0;
    end
    if (bus.w_i_rvalid || bus.w_d_rvalid) begin
      n_rv++;
      chk1("rvalid_exclusive", bus.w_i_rvalid & bus.w_d_rvalid, 1'b0);
      if (sb.size() == 0) begin
        check("unexpected_rvalid", {30'd0, bus.w_i_rvalid, bus.w_d_rvalid}, 32'd0);
      end else begin
        e = sb.pop_front();
        chk1("rvalid_port", bus.w_d_rvalid, e.is_d);
        if (e.chk) check(e.is_d ? "d_rdata" : "i_rdata",
                         e.is_d ? bus.w_d_rdata : bus.w_i_rdata, e.data);
      end
    end
  endtask

  task automatic wait_gnt(input logic is_d, input string tag);
    logic got = 1'b0;
    for (int k = 0; k < 50 && !got; k++) begin
      #1;
      got = is_d ? bus.w_d_gnt : bus.w_i_gnt;
      if (!got) tick();
    end
    chk1({tag, "_gnt"}, got, 1'b1);
  endtask

  task automatic wait_drain(input string tag);
    for (int k = 0; k < 60 && (sb.size() != 0 || bus.w_busy); k++) tick();
    check({tag, "_drain"}, 32'(sb.size()), 32'd0);
  endtask

  task automatic i_fetch(input logic [31:0] a, input logic [31:0] exp);
    bus.w_i_req  = 1'b1;
    bus.w_i_addr = a;
    exp_i_data   = exp;
    wait_gnt(1'b0, "i_fetch");
    tick();
    bus.w_i_req = 1'b0;
  endtask

  task automatic d_xfer(input logic we, input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] exp);
    bus.w_d_req   = 1'b1;
    bus.w_d_we    = we;
    bus.w_d_addr  = a;
    bus.w_d_wdata = wd;
    exp_d_data    = exp;
    wait_gnt(1'b1, "d_xfer");
    tick();
    bus.w_d_req = 1'b0;
    chk1("d_m_req", bus.w_m_req, 1'b1);
    chk1("d_m_we", bus.w_m_we, we);
    check("d_m_addr", bus.w_m_addr, a);
    check("d_m_wdata", bus.w_m_wdata, we ? wd : bus.w_m_wdata);
    if (we) check("d_m_wdata_store", bus.w_m_wdata, wd);
  endtask

  task automatic check_reset_vals(input string p);
    chk1({p, "_i_gnt"}, bus.w_i_gnt, 1'b0);
    chk1({p, "_d_gnt"}, bus.w_d_gnt, 1'b0);
    chk1({p, "_busy"}, bus.w_busy, 1'b0);
    chk1({p, "_m_req"}, bus.w_m_req, 1'b0);
    chk1({p, "_m_we"}, bus.w_m_we, 1'b0);
    check({p, "_m_addr"}, bus.w_m_addr, 32'd0);
    check({p, "_m_wdata"}, bus.w_m_wdata, 32'd0);
    chk1({p, "_i_rvalid"}, bus.w_i_rvalid, 1'b0);
    chk1({p, "_d_rvalid"}, bus.w_d_rvalid, 1'b0);
    check({p, "_i_rdata"}, bus.w_i_rdata, 32'd0);
    check({p, "_d_rdata"}, bus.w_d_rdata, 32'd0);
    chk1({p, "_err"}, bus.w_err, 1'b0);
  endtask

  initial begin
    int rv0;
    bus.w_i_req = 1'b0; bus.w_i_addr = '0;
    bus.w_d_req = 1'b0; bus.w_d_we = 1'b0; bus.w_d_addr = '0; bus.w_d_wdata = '0;
    bus.w_m_ready = 1'b0; bus.w_m_rvalid = 1'b0; bus.w_m_rdata = '0;
    mem[32'h40] = 32'h0000_0013;
    mem[32'h80] = 32'h0000_1234;

    // Reset state with both requests pending.
    bus.w_i_req = 1'b1; bus.w_d_req = 1'b1; bus.w_i_addr = 32'h40; bus.w_d_addr = 32'h44;
    tick(); tick();
    check_reset_vals("por");
    bus.w_i_req = 1'b0; bus.w_d_req = 1'b0;
    tick();
    w_rst_n = 1'b1;
    tick();

    // Single fetch, cycle by cycle from grant N.
    ready_delay = 0; rv_delay = 1; exp_i_data = 32'h13;
    bus.w_i_req = 1'b1; bus.w_i_addr = 32'h40;
    #1;
    chk1("fetch_i_gnt_N", bus.w_i_gnt, 1'b1);
    chk1("fetch_d_gnt_N", bus.w_d_gnt, 1'b0);
    tick();
    bus.w_i_req = 1'b0;
    #1;
    chk1("fetch_m_req_N1", bus.w_m_req, 1'b1);
    check("fetch_m_addr_N1", bus.w_m_addr, 32'h40);
    chk1("fetch_m_we_N1", bus.w_m_we, 1'b0);
    chk1("fetch_i_gnt_N1", bus.w_i_gnt, 1'b0);
    tick();
    chk1("fetch_m_req_N2", bus.w_m_req, 1'b0);
    chk1("fetch_busy_N2", bus.w_busy, 1'b1);
    tick();
    chk1("fetch_i_rvalid_N3", bus.w_i_rvalid, 1'b0);
    tick();
    chk1("fetch_i_rvalid_N4", bus.w_i_rvalid, 1'b1);
    check("fetch_i_rdata_N4", bus.w_i_rdata, 32'h13);
    chk1("fetch_d_rvalid_N4", bus.w_d_rvalid, 1'b0);
    tick();
    chk1("fetch_i_rvalid_N5", bus.w_i_rvalid, 1'b0);
    check("fetch_i_rdata_hold", bus.w_i_rdata, 32'h13);
    chk1("fetch_busy_N5", bus.w_busy, 1'b0);

    // Store then load through the behavioural memory.
    d_xfer(1'b1, 32'h100, 32'hDEAD_BEEF, 32'h0);
    wait_drain("store");
    d_xfer(1'b0, 32'h100, 32'h0, 32'hDEAD_BEEF);
    wait_drain("load");
    check("load_rdata", bus.w_d_rdata, 32'hDEAD_BEEF);

    // Contention: both held high, expect D,D,D,D,I repeating.
    rv_delay = 0;
    gseq.delete();
    bus.w_i_req = 1'b1; bus.w_i_addr = 32'h200; exp_i_data = init_val(32'h200);
    bus.w_d_req = 1'b1; bus.w_d_we = 1'b0; bus.w_d_addr = 32'h300; exp_d_data = init_val(32'h300);
    for (int k = 0; k < 300 && gseq.size() < 10; k++) tick();
    bus.w_i_req = 1'b0; bus.w_d_req = 1'b0;
    check("cont_grants", 32'(gseq.size()), 32'd10);
    for (int k = 0; k < 10; k++) begin
      chk1($sformatf("cont_grant%0d_is_d", k), (k < gseq.size()) ? gseq[k] : 1'bx,
           (k % 5 == 4) ? 1'b0 : 1'b1);
    end
    wait_drain("cont");

    // Backpressure: six ISSUE cycles, new D request arriving meanwhile.
    ready_delay = 5;
    i_fetch(32'h204, init_val(32'h204));
    bus.w_d_req = 1'b1; bus.w_d_we = 1'b0; bus.w_d_addr = 32'h304; exp_d_data = init_val(32'h304);
    for (int k = 0; k < 6; k++) begin
      #1;
      chk1($sformatf("bp_m_req%0d", k), bus.w_m_req, 1'b1);
      check($sformatf("bp_m_addr%0d", k), bus.w_m_addr, 32'h204);
      chk1($sformatf("bp_d_gnt%0d", k), bus.w_d_gnt, 1'b0);
      chk1($sformatf("bp_i_gnt%0d", k), bus.w_i_gnt, 1'b0);
      tick();
    end
    ready_delay = 0;
    wait_gnt(1'b1, "bp_d");
    chk1("bp_gnt_in_idle", bus.w_busy, 1'b0);
    tick();
    bus.w_d_req = 1'b0;
    wait_drain("bp");

    // Spurious response in IDLE.
    chk1("spur_err_before", bus.w_err, 1'b0);
    rv0 = n_rv;
    inject_rvalid = 1'b1;
    tick();
    inject_rvalid = 1'b0;
    tick();
    chk1("spur_err_set", bus.w_err, 1'b1);
    tick();
    chk1("spur_err_sticky", bus.w_err, 1'b1);
    check("spur_no_rvalid", 32'(n_rv - rv0), 32'd0);
    rv_delay = 1;
    i_fetch(32'h80, 32'h0000_1234);
    wait_drain("spur_fetch");
    check("spur_fetch_rdata", bus.w_i_rdata, 32'h0000_1234);
    chk1("spur_err_still", bus.w_err, 1'b1);

    // Reset during ISSUE with requests pending.
    ready_delay = 3;
    i_fetch(32'h208, init_val(32'h208));
    bus.w_i_req = 1'b1; bus.w_d_req = 1'b1; bus.w_d_addr = 32'h308;
    #1;
    chk1("rs_issue_m_req", bus.w_m_req, 1'b1);
    w_rst_n = 1'b0;
    #1;
    check_reset_vals("rs_issue");
    sb.delete();
    tick(); tick();
    bus.w_i_req = 1'b0; bus.w_d_req = 1'b0;
    w_rst_n = 1'b1;
    ready_delay = 0;
    rv0 = n_rv;
    for (int k = 0; k < 6; k++) tick();
    check("rs_issue_no_rvalid", 32'(n_rv - rv0), 32'd0);
    chk1("rs_issue_idle", bus.w_busy, 1'b0);

    // Reset during WAIT, then a late memory response.
    rv_delay = 3;
    i_fetch(32'h20C, init_val(32'h20C));
    tick();
    chk1("rs_wait_busy", bus.w_busy, 1'b1);
    chk1("rs_wait_m_req", bus.w_m_req, 1'b0);
    bus.w_i_req = 1'b1;
    w_rst_n = 1'b0;
    #1;
    check_reset_vals("rs_wait");
    sb.delete();
    tick();
    bus.w_i_req = 1'b0;
    w_rst_n = 1'b1;
    rv0 = n_rv;
    inject_rvalid = 1'b1;
    tick();
    inject_rvalid = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    chk1("rs_late_err", bus.w_err, 1'b1);
    check("rs_wait_no_rvalid", 32'(n_rv - rv0), 32'd0);
    chk1("rs_wait_idle", bus.w_busy, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
